// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin arbiter sharing one down-counting timer between
// N_REQ requesters. Each owner gets the timer loaded with its delay, the tick
// strobe gated into the count enable, and a one-cycle done pulse on expiry.
// Optional feature: define TIMER_ARB_WATCHDOG_EN to add a tick-count
// watchdog that forces completion (with timeout_err) when the timer never
// expires.
module timer_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 9
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_value,
  input  logic                   tick,
  input  logic                   timer_expired,
  output logic                   timer_load,
  output logic [WIDTH-1:0]       timer_load_value,
  output logic                   timer_count_en,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
`ifdef TIMER_ARB_WATCHDOG_EN
  output logic                   timeout_err,
`endif
  output logic                   busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t           state;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    owner;
  logic [WIDTH-1:0] val_q;

  logic [IW-1:0]    pick;
  logic             found;
  logic [IW-1:0]    nxt_ptr;
  logic [N_REQ-1:0] owner_oh;
  logic             owner_req;

`ifdef TIMER_ARB_WATCHDOG_EN
  // Counts ticks seen in RUN; WIDTH+1 bits so value+2 never wraps.
  logic [WIDTH:0]   wd_cnt;
  logic [WIDTH:0]   wd_nxt;
  logic [WIDTH:0]   wd_lim;
  logic             wd_hit;
  logic             to_q;

  assign wd_nxt = wd_cnt + (WIDTH+1)'(1);
  assign wd_lim = {1'b0, val_q} + (WIDTH+1)'(2);
  assign wd_hit = tick && (wd_nxt == wd_lim);
`endif

  // Round-robin search: walk from farthest to nearest so the first set bit
  // at or after rr_ptr (with wrap) is the one left in pick.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      int idx;
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (req[idx]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end
    end
  end

  assign nxt_ptr   = (owner == IW'(N_REQ-1)) ? '0 : owner + 1'b1;
  assign owner_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << owner;
  assign owner_req = req[owner];

  // Arbitration FSM: latch owner/value in IDLE, load, run until expiry or
  // cancel, then a single DONE cycle that advances the round-robin pointer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      val_q  <= '0;
`ifdef TIMER_ARB_WATCHDOG_EN
      wd_cnt <= '0;
      to_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            owner <= pick;
            val_q <= req_value[pick*WIDTH +: WIDTH];
            state <= LOAD;
          end
        end
        LOAD: begin
          // Zero-delay requests skip the timer entirely.
          state <= (val_q != '0) ? RUN : DONE;
`ifdef TIMER_ARB_WATCHDOG_EN
          wd_cnt <= '0;
          to_q   <= 1'b0;
`endif
        end
        RUN: begin
          // Expiry beats a same-cycle cancel.
          if (timer_expired) begin
            state <= DONE;
`ifdef TIMER_ARB_WATCHDOG_EN
          end else if (wd_hit) begin
            state <= DONE;
            to_q  <= 1'b1;
`endif
          end else if (!owner_req) begin
            state  <= IDLE;
            rr_ptr <= nxt_ptr;
          end
`ifdef TIMER_ARB_WATCHDOG_EN
          else if (tick) begin
            wd_cnt <= wd_nxt;
          end
`endif
        end
        DONE: begin
          rr_ptr <= nxt_ptr;
          state  <= IDLE;
`ifdef TIMER_ARB_WATCHDOG_EN
          to_q   <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode from registered state so async reset clears them at once;
  // only the count enable looks at live inputs (tick, cancel).
  assign busy             = (state != IDLE);
  assign grant            = busy ? owner_oh : '0;
  assign done             = (state == DONE) ? owner_oh : '0;
  assign timer_load       = (state == LOAD) && (val_q != '0);
  assign timer_load_value = timer_load ? val_q : '0;
  assign timer_count_en   = (state == RUN) && tick && owner_req;
`ifdef TIMER_ARB_WATCHDOG_EN
  assign timeout_err      = (state == DONE) && to_q;
`endif

endmodule

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter: directed stimulus with scoreboard queues for done and
// timer_load events; independent monitors pop and compare on each event.
module tb_timer_arbiter;
  localparam int N = 4;
  localparam int W = 9;

  logic             clock;
  logic             reset_n;
  logic [N-1:0]     req;
  logic [N*W-1:0]   req_value;
  logic             tick;
  logic             timer_expired;
  logic             timer_load;
  logic [W-1:0]     timer_load_value;
  logic             timer_count_en;
  logic [N-1:0]     grant;
  logic [N-1:0]     done;
  logic             busy;
`ifdef TIMER_ARB_WATCHDOG_EN
  logic             timeout_err;
`endif

  timer_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_value(req_value),
    .tick(tick), .timer_expired(timer_expired), .timer_load(timer_load),
    .timer_load_value(timer_load_value), .timer_count_en(timer_count_en),
    .grant(grant), .done(done),
`ifdef TIMER_ARB_WATCHDOG_EN
    .timeout_err(timeout_err),
`endif
    .busy(busy)
  );

  typedef struct { logic [N-1:0] vec; int cyc; logic to; } done_t;
  typedef struct { logic [W-1:0] val; logic [N-1:0] g; int cyc; } load_t;

  done_t dq[$];
  load_t lq[$];
  done_t dm;
  load_t lm;
  int    cyc = 0;
  int    n_chk = 0;
  int    n_fail = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] one;
    one = 1;
    return one << i;
  endfunction

  // Done monitor: every done pulse must match the head of the queue.
  always @(negedge clock) begin
    if (reset_n) begin
      if (done !== '0) begin
        n_chk++;
        if (dq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done act=%b cyc=%0d", done, cyc);
        end else begin
          dm = dq.pop_front();
          if (done !== dm.vec || cyc != dm.cyc) begin
            n_fail++;
            $display("FAIL done act=%b@%0d exp=%b@%0d", done, cyc, dm.vec, dm.cyc);
          end
`ifdef TIMER_ARB_WATCHDOG_EN
          n_chk++;
          if (timeout_err !== dm.to) begin
            n_fail++;
            $display("FAIL timeout_err act=%b exp=%b", timeout_err, dm.to);
          end
`endif
        end
      end
`ifdef TIMER_ARB_WATCHDOG_EN
      else if (timeout_err !== 1'b0) begin
        n_chk++;
        n_fail++;
        $display("FAIL stray_timeout_err act=%b exp=0", timeout_err);
      end
`endif
    end
  end

  // Load monitor: every timer_load must match value, grant and (if given) cycle.
  always @(negedge clock) begin
    if (reset_n && timer_load === 1'b1) begin
      n_chk++;
      if (lq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_load val=%0d cyc=%0d", timer_load_value, cyc);
      end else begin
        lm = lq.pop_front();
        if (timer_load_value !== lm.val || grant !== lm.g || (lm.cyc >= 0 && cyc != lm.cyc)) begin
          n_fail++;
          $display("FAIL load act=%0d/%b@%0d exp=%0d/%b@%0d",
                   timer_load_value, grant, cyc, lm.val, lm.g, lm.cyc);
        end
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0;
    tick = 1'b0;
    timer_expired = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic wait_load();
    int n = 0;
    while (timer_load !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("load_wait", {31'd0, timer_load}, 32'd1);
  endtask

  // Act as the timer: tick val times, then pulse expiry; done expected next cycle.
  task automatic serve(input int own, input int val, input int ecyc);
    lq.push_back('{val: W'(val), g: oh(own), cyc: ecyc});
    wait_load();
    for (int i = 0; i < val; i++) begin
      step();
      tick = 1'b1;
    end
    step();
    tick = 1'b0;
    timer_expired = 1'b1;
    dq.push_back('{vec: oh(own), cyc: cyc + 1, to: 1'b0});
    step();
    timer_expired = 1'b0;
  endtask

  initial begin
    req_value = '0;
    reset_n = 1'b0;
    req = '0;
    tick = 1'b0;
    timer_expired = 1'b0;
    #2;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_load", 32'(timer_load), 32'd0);
    chk("rst_load_value", 32'(timer_load_value), 32'd0);
    chk("rst_count_en", 32'(timer_count_en), 32'd0);
    do_reset();

    // Single request; later req_value change must not affect the grant.
    req_value[0*W +: W] = 9'd5;
    req = 4'b0001;
    step();
    req_value[0*W +: W] = 9'd9;
    serve(0, 5, cyc);
    req = '0;
    step();
    chk("single_busy_low", 32'(busy), 32'd0);
    chk("single_grant_low", 32'(grant), 32'd0);

    // Round-robin with all requesters active.
    do_reset();
    for (int i = 0; i < N; i++) req_value[i*W +: W] = 9'd3;
    req = 4'b1111;
    serve(0, 3, -1);
    serve(1, 3, -1);
    serve(2, 3, -1);
    serve(3, 3, -1);
    serve(0, 3, -1);
    req = '0;
    step();

    // Zero delay, with stray tick and expiry while idle.
    step();
    req_value[2*W +: W] = 9'd0;
    req = 4'b0100;
    tick = 1'b1;
    timer_expired = 1'b1;
    #1;
    chk("idle_count_en", 32'(timer_count_en), 32'd0);
    dq.push_back('{vec: 4'b0100, cyc: cyc + 2, to: 1'b0});
    step();
    timer_expired = 1'b0;
    chk("zero_load_count_en", 32'(timer_count_en), 32'd0);
    step();
    req = '0;
    tick = 1'b0;
    step();
    step();

    // Cancel after 3 ticks; next arbitration from rr_ptr=2 picks requester 0.
    do_reset();
    req_value[1*W +: W] = 9'd9;
    req = 4'b0010;
    lq.push_back('{val: 9'd9, g: 4'b0010, cyc: -1});
    wait_load();
    for (int i = 0; i < 3; i++) begin
      step();
      tick = 1'b1;
    end
    step();
    req = '0;
    #1;
    chk("cancel_count_en", 32'(timer_count_en), 32'd0);
    step();
    tick = 1'b0;
    chk("cancel_grant", 32'(grant), 32'd0);
    chk("cancel_busy", 32'(busy), 32'd0);
    req_value[0*W +: W] = 9'd7;
    req_value[1*W +: W] = 9'd2;
    req = 4'b0011;
    serve(0, 7, -1);
    req = '0;
    step();
    step();

    // Async reset in RUN.
    do_reset();
    req_value[0*W +: W] = 9'd8;
    req = 4'b0001;
    lq.push_back('{val: 9'd8, g: 4'b0001, cyc: -1});
    wait_load();
    step();
    tick = 1'b1;
    #1;
    chk("run_count_en", 32'(timer_count_en), 32'd1);
    chk("run_grant", 32'(grant), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_grant", 32'(grant), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_count_en", 32'(timer_count_en), 32'd0);
    tick = 1'b0;
    req = '0;
    step();
    reset_n = 1'b1;
    step();
    step();
    chk("arst_after_busy", 32'(busy), 32'd0);

`ifdef TIMER_ARB_WATCHDOG_EN
    // Watchdog: value 4, no expiry; done+timeout_err after the 6th tick.
    do_reset();
    req_value[0*W +: W] = 9'd4;
    req = 4'b0001;
    lq.push_back('{val: 9'd4, g: 4'b0001, cyc: -1});
    wait_load();
    for (int i = 0; i < 6; i++) begin
      step();
      tick = 1'b1;
    end
    dq.push_back('{vec: 4'b0001, cyc: cyc + 1, to: 1'b1});
    step();
    tick = 1'b0;
    req = '0;
    step();
    step();
`endif

    step();
    chk("done_queue_empty", 32'(dq.size()), 32'd0);
    chk("load_queue_empty", 32'(lq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "simulation time limit");
  end

endmodule
